// File: rtl/core_disp.sv
// core_disp: display stage of the reaction-timer core.
// Multiplexes a 6-digit common-cathode 7-segment display from a per-frame
// snapshot of the core's display-select code and packed BCD results.
//
// Ports:
//   i_clk    clock
//   i_rst_n  asynchronous active-low reset
//   i_dst    display select: 000 best, 001 wait, 010 measure, 011 early, 110 last
//   i_last   last result, 6 packed BCD digits, nibble 5 = MS digit
//   i_best   best result, same format (all-F = no result)
//   o_seg    segments gfedcba, bit0 = a, active high
//   o_dp     decimal point, active high
//   o_dig    one-hot digit enable, bit5 = leftmost, active high
//   o_frame  one-cycle pulse after a new snapshot is taken
module core_disp #(
  parameter int SCAN_W  = 16,
  parameter int BLANK   = 64,
  parameter int BLINK_W = 3
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [2:0]  i_dst,
  input  logic [23:0] i_last,
  input  logic [23:0] i_best,
  output logic [6:0]  o_seg,
  output logic        o_dp,
  output logic [5:0]  o_dig,
  output logic        o_frame
);

  localparam logic [SCAN_W-1:0] PRESC_MAX = '1;
  localparam logic [SCAN_W-1:0] BLANK_C   = SCAN_W'(BLANK);

  logic [SCAN_W-1:0]  presc_q, presc_d;
  logic [2:0]         idx_q, idx_d;
  logic [2:0]         snap_mode_q, snap_mode_d;
  logic [23:0]        snap_val_q, snap_val_d;
  logic [BLINK_W-1:0] frm_q, frm_d;
  logic               phase_q, phase_d;
  logic [6:0]         seg_q, seg_d;
  logic               dp_q, dp_d;
  logic [5:0]         dig_q, dig_d;
  logic               frame_q, frame_d;
  logic               tc, fwrap;
  logic [7:0]         glyph_w;

  function automatic logic [6:0] seg7(input logic [3:0] nib);
    case (nib)
      4'd0:    seg7 = 7'h3F;
      4'd1:    seg7 = 7'h06;
      4'd2:    seg7 = 7'h5B;
      4'd3:    seg7 = 7'h4F;
      4'd4:    seg7 = 7'h66;
      4'd5:    seg7 = 7'h6D;
      4'd6:    seg7 = 7'h7D;
      4'd7:    seg7 = 7'h07;
      4'd8:    seg7 = 7'h7F;
      4'd9:    seg7 = 7'h6F;
      default: seg7 = 7'h40;  // non-BCD nibble shows a dash
    endcase
  endfunction

  // Returns {dp, seg} for digit idx of the snapshot.
  function automatic logic [7:0] glyph(input logic [2:0] mode, input logic [23:0] val,
                                       input logic [2:0] idx, input logic phase);
    logic [3:0] nib;
    logic       lz;
    case (idx)
      3'd5:    nib = val[23:20];
      3'd4:    nib = val[19:16];
      3'd3:    nib = val[15:12];
      3'd2:    nib = val[11:8];
      3'd1:    nib = val[7:4];
      default: nib = val[3:0];
    endcase
    // Leading-zero suppression only reaches the two leftmost digits so the
    // millisecond digit is always shown.
    lz = ((idx == 3'd5) && (val[23:20] == 4'h0)) ||
         ((idx == 3'd4) && (val[23:16] == 8'h00));
    glyph = 8'h00;
    case (mode)
      3'b000, 3'b110: begin
        glyph[6:0] = lz ? 7'h00 : seg7(nib);
        glyph[7]   = (idx == 3'd3);
      end
      3'b001:  glyph = 8'h40;
      3'b011:  glyph = (phase && (idx == 3'd5)) ? 8'h79 : 8'h00;
      default: glyph = 8'h00;
    endcase
  endfunction

  always_comb begin
    tc          = (presc_q == PRESC_MAX);
    fwrap       = tc && (idx_q == 3'd0);
    presc_d     = presc_q + SCAN_W'(1);
    idx_d       = idx_q;
    snap_mode_d = snap_mode_q;
    snap_val_d  = snap_val_q;
    frm_d       = frm_q;
    phase_d     = phase_q;
    frame_d     = fwrap;

    if (tc) begin
      idx_d = (idx_q == 3'd0) ? 3'd5 : idx_q - 3'd1;
    end

    // Frame wrap: snapshot inputs and advance the blink timebase. A mode
    // change restarts the blink so EARLY always appears immediately.
    if (fwrap) begin
      snap_mode_d = i_dst;
      snap_val_d  = (i_dst == 3'b110) ? i_last : i_best;
      if (i_dst != snap_mode_q) begin
        frm_d   = '0;
        phase_d = 1'b1;
      end else begin
        frm_d = frm_q + BLINK_W'(1);
        if (frm_q == '1) begin
          phase_d = ~phase_q;
        end
      end
    end

    // Output stage: anti-ghost blanking at the start of each dwell.
    glyph_w = glyph(snap_mode_q, snap_val_q, idx_q, phase_q);
    dig_d   = (presc_q >= BLANK_C) ? (6'b000001 << idx_q) : 6'b000000;
    seg_d   = (dig_d != 6'b0) ? glyph_w[6:0] : 7'h00;
    dp_d    = (dig_d != 6'b0) ? glyph_w[7] : 1'b0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      presc_q     <= '0;
      idx_q       <= 3'd5;
      snap_mode_q <= 3'b000;
      snap_val_q  <= 24'hFFFFFF;
      frm_q       <= '0;
      phase_q     <= 1'b1;
      seg_q       <= 7'h00;
      dp_q        <= 1'b0;
      dig_q       <= 6'b0;
      frame_q     <= 1'b0;
    end else begin
      presc_q     <= presc_d;
      idx_q       <= idx_d;
      snap_mode_q <= snap_mode_d;
      snap_val_q  <= snap_val_d;
      frm_q       <= frm_d;
      phase_q     <= phase_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
      dig_q       <= dig_d;
      frame_q     <= frame_d;
    end
  end

  assign o_seg   = seg_q;
  assign o_dp    = dp_q;
  assign o_dig   = dig_q;
  assign o_frame = frame_q;

endmodule
